// File: rtl/osc_lock_ctrl.sv
// Calibration and lock sequencer for the ring oscillator: a successive-approximation search over the
// coarse then fine varactor codes, a final verification window, then hand-over to edge injection.
module osc_lock_ctrl #(
    parameter int CNT_W      = 12,
    parameter int WIN_W      = 8,
    parameter int SETTLE_CYC = 16
) (
    input  logic             ref_clk,
    input  logic             rst,
    input  logic             cal_start,
    input  logic [CNT_W-1:0] target_cnt,
    input  logic [CNT_W-1:0] tol_cnt,
    input  logic             osc_div_sync,
    output logic             glob_en,
    output logic [7:0]       delay_con_msb,
    output logic [4:0]       delay_con_lsb,
    output logic             inj_en,
    output logic             cal_busy,
    output logic             cal_done,
    output logic             cal_err,
    output logic [CNT_W-1:0] meas_cnt
);

    localparam int SET_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
    localparam int TW    = ((WIN_W > SET_W) ? WIN_W : SET_W) + 1;
    localparam logic [TW-1:0] SETTLE_LAST = TW'(SETTLE_CYC - 1);
    localparam logic [TW-1:0] WIN_LAST    = TW'((1 << WIN_W) - 1);

    typedef enum logic [2:0] {IDLE, SETTLE, MEASURE, DECIDE, CHECK, LOCKED} state_t;

    state_t           state_q, state_d;
    logic             start_q1, start_q2;
    logic [CNT_W-1:0] tgt_q, tgt_d, tol_q, tol_d;
    logic             glob_q, glob_d, inj_q, inj_d, busy_q, busy_d, done_q, done_d, err_q, err_d;
    logic [7:0]       msb_q, msb_d;
    logic [4:0]       lsb_q, lsb_d;
    logic [CNT_W-1:0] meas_q, meas_d, cnt_q, cnt_d;
    logic             phase_q, phase_d;   // 0: coarse code, 1: fine code
    logic [2:0]       bit_q, bit_d;
    logic             final_q, final_d;
    logic [TW-1:0]    timer_q, timer_d;
    logic             prev_q, prev_d;

    logic             rise, start_now, keep;
    logic [CNT_W-1:0] cnt_inc;
    logic [CNT_W:0]   diff;
    logic [2:0]       bit_m1;

    assign rise      = start_q1 & ~start_q2;
    assign start_now = rise && (state_q == IDLE || state_q == LOCKED);
    assign keep      = meas_q > tgt_q;
    assign bit_m1    = bit_q - 3'd1;
    // Saturating edge count, including an edge seen on the current cycle
    assign cnt_inc   = (osc_div_sync && !prev_q && !(&cnt_q)) ? cnt_q + CNT_W'(1) : cnt_q;

    always_comb begin
        if (meas_q > tgt_q) diff = {1'b0, meas_q} - {1'b0, tgt_q};
        else                diff = {1'b0, tgt_q} - {1'b0, meas_q};
    end

    always_comb begin
        state_d = state_q;
        tgt_d   = tgt_q;
        tol_d   = tol_q;
        glob_d  = glob_q;
        inj_d   = inj_q;
        busy_d  = busy_q;
        done_d  = done_q;
        err_d   = err_q;
        msb_d   = msb_q;
        lsb_d   = lsb_q;
        meas_d  = meas_q;
        cnt_d   = cnt_q;
        phase_d = phase_q;
        bit_d   = bit_q;
        final_d = final_q;
        timer_d = timer_q;
        prev_d  = prev_q;

        case (state_q)
            SETTLE: begin
                timer_d = timer_q + TW'(1);
                if (timer_q == SETTLE_LAST) begin
                    state_d = MEASURE;
                    timer_d = '0;
                    cnt_d   = '0;
                    prev_d  = 1'b0;
                end
            end
            MEASURE: begin
                timer_d = timer_q + TW'(1);
                cnt_d   = cnt_inc;
                prev_d  = osc_div_sync;
                if (timer_q == WIN_LAST) begin
                    meas_d  = cnt_inc;
                    state_d = final_q ? CHECK : DECIDE;
                end
            end
            DECIDE: begin
                state_d = SETTLE;
                timer_d = '0;
                if (!phase_q) begin
                    msb_d[bit_q] = keep;
                    if (bit_q != 3'd0) begin
                        msb_d[bit_m1] = 1'b1;
                        bit_d         = bit_m1;
                    end else begin
                        phase_d = 1'b1;
                        bit_d   = 3'd4;
                    end
                end else begin
                    lsb_d[bit_q] = keep;
                    if (bit_q != 3'd0) begin
                        lsb_d[bit_m1] = 1'b1;
                        bit_d         = bit_m1;
                    end else begin
                        final_d = 1'b1;
                    end
                end
            end
            CHECK: begin
                err_d   = diff > {1'b0, tol_q};
                state_d = LOCKED;
            end
            LOCKED: begin
                busy_d = 1'b0;
                done_d = 1'b1;
                inj_d  = ~err_q;
            end
            default: ;
        endcase

        // A start from IDLE or LOCKED overrides everything above
        if (start_now) begin
            tgt_d   = target_cnt;
            tol_d   = tol_cnt;
            glob_d  = 1'b1;
            busy_d  = 1'b1;
            done_d  = 1'b0;
            err_d   = 1'b0;
            inj_d   = 1'b0;
            msb_d   = 8'h80;
            lsb_d   = 5'h10;
            phase_d = 1'b0;
            bit_d   = 3'd7;
            final_d = 1'b0;
            timer_d = '0;
            state_d = SETTLE;
        end
    end

    always_ff @(posedge ref_clk) begin
        if (rst) begin
            state_q  <= IDLE;
            start_q1 <= 1'b0;
            start_q2 <= 1'b0;
            tgt_q    <= '0;
            tol_q    <= '0;
            glob_q   <= 1'b0;
            inj_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            msb_q    <= 8'h80;
            lsb_q    <= 5'h10;
            meas_q   <= '0;
            cnt_q    <= '0;
            phase_q  <= 1'b0;
            bit_q    <= 3'd7;
            final_q  <= 1'b0;
            timer_q  <= '0;
            prev_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            start_q1 <= cal_start;
            start_q2 <= start_q1;
            tgt_q    <= tgt_d;
            tol_q    <= tol_d;
            glob_q   <= glob_d;
            inj_q    <= inj_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            err_q    <= err_d;
            msb_q    <= msb_d;
            lsb_q    <= lsb_d;
            meas_q   <= meas_d;
            cnt_q    <= cnt_d;
            phase_q  <= phase_d;
            bit_q    <= bit_d;
            final_q  <= final_d;
            timer_q  <= timer_d;
            prev_q   <= prev_d;
        end
    end

    assign glob_en       = glob_q;
    assign delay_con_msb = msb_q;
    assign delay_con_lsb = lsb_q;
    assign inj_en        = inj_q;
    assign cal_busy      = busy_q;
    assign cal_done      = done_q;
    assign cal_err       = err_q;
    assign meas_cnt      = meas_q;

endmodule

// File: tb/tb_osc_lock_ctrl.sv
// Directed bench for osc_lock_ctrl: a behavioural oscillator whose edge count per window depends on the
// coarse code, plus a second wide-window instance for counter saturation.
module tb_osc_lock_ctrl;

    localparam int CW  = 12;
    localparam int WW  = 10;
    localparam int SC  = 4;
    localparam int W   = 1 << WW;
    localparam int P   = SC + W + 1;
    localparam int LAT = 14 * P + 2;
    localparam int WW2 = 13;
    localparam int SC2 = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst = 1'b1, cal_start = 1'b0, osc = 1'b0;
    logic [CW-1:0] target = '0, tol = '0;
    logic          glob, inj, busy, done, err;
    logic [7:0]    msb;
    logic [4:0]    lsb;
    logic [CW-1:0] meas;

    logic          cs2 = 1'b0, osc2 = 1'b0;
    logic          glob2, inj2, busy2, done2, err2;
    logic [7:0]    msb2;
    logic [4:0]    lsb2;
    logic [CW-1:0] meas2;

    osc_lock_ctrl #(.CNT_W(CW), .WIN_W(WW), .SETTLE_CYC(SC)) dut (
        .ref_clk(clk), .rst(rst), .cal_start(cal_start), .target_cnt(target), .tol_cnt(tol),
        .osc_div_sync(osc), .glob_en(glob), .delay_con_msb(msb), .delay_con_lsb(lsb),
        .inj_en(inj), .cal_busy(busy), .cal_done(done), .cal_err(err), .meas_cnt(meas));

    osc_lock_ctrl #(.CNT_W(CW), .WIN_W(WW2), .SETTLE_CYC(SC2)) sat (
        .ref_clk(clk), .rst(rst), .cal_start(cs2), .target_cnt(12'd100), .tol_cnt(12'd4),
        .osc_div_sync(osc2), .glob_en(glob2), .delay_con_msb(msb2), .delay_con_lsb(lsb2),
        .inj_en(inj2), .cal_busy(busy2), .cal_done(done2), .cal_err(err2), .meas_cnt(meas2));

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int compared = 0, failed = 0;
    int k0 = 0, mode = 0;
    bit active = 1'b0;

    // Oscillator model: N rising edges in each measurement window, toggling freely elsewhere
    always @(negedge clk) begin
        int c, r, m, n;
        c = active ? cyc - k0 - 1 : -1;
        if (c >= 0) begin
            r = c % P;
            if (r >= SC && r < SC + W) begin
                m = r - SC;
                n = (mode == 0) ? 512 - int'(msb) : 300;
                osc = (m % 2 == 1) && ((m - 1) / 2 < n);
            end else begin
                osc = ~osc;
            end
        end else begin
            osc = ~osc;
        end
        osc2 = ~osc2;
    end

    task automatic pulse_start();
        @(negedge clk);
        cal_start = 1'b1;
        @(negedge clk);
        k0        = cyc;
        active    = 1'b1;
        cal_start = 1'b0;
    endtask

    task automatic wait_done(output int lat);
        lat = -1;
        for (int i = 0; i < LAT + 200; i++) begin
            @(negedge clk);
            if (cyc > k0 + 1 && done) begin
                lat = cyc - k0;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        compared++; if (glob !== 1'b0) begin failed++; $display("FAIL rst_glob: got %b want 0", glob); end
        compared++; if (msb !== 8'h80) begin failed++; $display("FAIL rst_msb: got %h want 80", msb); end
        compared++; if (lsb !== 5'h10) begin failed++; $display("FAIL rst_lsb: got %h want 10", lsb); end
        compared++; if (inj !== 1'b0) begin failed++; $display("FAIL rst_inj: got %b want 0", inj); end
        compared++; if (busy !== 1'b0) begin failed++; $display("FAIL rst_busy: got %b want 0", busy); end
        compared++; if (done !== 1'b0) begin failed++; $display("FAIL rst_done: got %b want 0", done); end
        compared++; if (err !== 1'b0) begin failed++; $display("FAIL rst_err: got %b want 0", err); end
        compared++; if (meas !== 12'h000) begin failed++; $display("FAIL rst_meas: got %h want 000", meas); end
        rst = 1'b0;
        repeat (5) @(negedge clk);
        compared++; if (glob !== 1'b0 || busy !== 1'b0 || msb !== 8'h80 || meas !== 12'h000)
            begin failed++; $display("FAIL idle_hold: got glob=%b busy=%b msb=%h meas=%h want 0 0 80 000", glob, busy, msb, meas); end
    endtask

    task automatic test_model_lock();
        int lat;
        mode = 0; target = 12'd400; tol = 12'd2;
        pulse_start();
        repeat (SC + 20) @(negedge clk);
        cal_start = 1'b1;
        @(negedge clk);
        cal_start = 1'b0;
        repeat (5) @(negedge clk);
        compared++; if (busy !== 1'b1 || msb !== 8'h80 || done !== 1'b0)
            begin failed++; $display("FAIL ignore_start: got busy=%b msb=%h done=%b want 1 80 0", busy, msb, done); end
        wait_done(lat);
        compared++; if (lat !== LAT) begin failed++; $display("FAIL lock_latency: got %0d want %0d", lat, LAT); end
        compared++; if (msb !== 8'h6F) begin failed++; $display("FAIL lock_msb: got %h want 6f", msb); end
        compared++; if (lsb !== 5'h1F) begin failed++; $display("FAIL lock_lsb: got %h want 1f", lsb); end
        compared++; if (meas !== 12'd401) begin failed++; $display("FAIL lock_meas: got %0d want 401", meas); end
        compared++; if (err !== 1'b0) begin failed++; $display("FAIL lock_err: got %b want 0", err); end
        compared++; if (inj !== 1'b1) begin failed++; $display("FAIL lock_inj: got %b want 1", inj); end
        compared++; if (busy !== 1'b0 || glob !== 1'b1)
            begin failed++; $display("FAIL lock_busy_glob: got busy=%b glob=%b want 0 1", busy, glob); end
    endtask

    task automatic test_restart_locked();
        @(negedge clk);
        cal_start = 1'b1;
        @(negedge clk);
        k0 = cyc;
        cal_start = 1'b0;
        @(negedge clk);
        compared++; if (inj !== 1'b0) begin failed++; $display("FAIL restart_inj: got %b want 0", inj); end
        compared++; if (msb !== 8'h80 || lsb !== 5'h10)
            begin failed++; $display("FAIL restart_codes: got msb=%h lsb=%h want 80 10", msb, lsb); end
        compared++; if (busy !== 1'b1 || done !== 1'b0)
            begin failed++; $display("FAIL restart_flags: got busy=%b done=%b want 1 0", busy, done); end
    endtask

    task automatic test_all_clear();
        int lat;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        mode = 1; target = 12'd400; tol = 12'd4;
        pulse_start();
        wait_done(lat);
        compared++; if (lat !== LAT) begin failed++; $display("FAIL clear_latency: got %0d want %0d", lat, LAT); end
        compared++; if (msb !== 8'h00 || lsb !== 5'h00)
            begin failed++; $display("FAIL clear_codes: got msb=%h lsb=%h want 00 00", msb, lsb); end
        compared++; if (meas !== 12'd300) begin failed++; $display("FAIL clear_meas: got %0d want 300", meas); end
        compared++; if (err !== 1'b1 || inj !== 1'b0)
            begin failed++; $display("FAIL clear_err_inj: got err=%b inj=%b want 1 0", err, inj); end
    endtask

    task automatic test_rst_lsb();
        int lat;
        mode = 0; target = 12'd400; tol = 12'd2;
        pulse_start();
        repeat (8 * P + 11) @(negedge clk);
        compared++; if (msb !== 8'h6F || lsb !== 5'h10 || busy !== 1'b1)
            begin failed++; $display("FAIL lsb_phase: got msb=%h lsb=%h busy=%b want 6f 10 1", msb, lsb, busy); end
        rst = 1'b1;
        @(negedge clk);
        compared++; if (glob !== 1'b0 || busy !== 1'b0 || inj !== 1'b0 || done !== 1'b0 || err !== 1'b0)
            begin failed++; $display("FAIL abort_flags: got glob=%b busy=%b inj=%b done=%b err=%b want 0", glob, busy, inj, done, err); end
        compared++; if (msb !== 8'h80 || lsb !== 5'h10 || meas !== 12'h000)
            begin failed++; $display("FAIL abort_data: got msb=%h lsb=%h meas=%h want 80 10 000", msb, lsb, meas); end
        rst = 1'b0;
        active = 1'b0;
        pulse_start();
        wait_done(lat);
        compared++; if (lat !== LAT) begin failed++; $display("FAIL relock_latency: got %0d want %0d", lat, LAT); end
        compared++; if (msb !== 8'h6F || lsb !== 5'h1F || inj !== 1'b1)
            begin failed++; $display("FAIL relock_result: got msb=%h lsb=%h inj=%b want 6f 1f 1", msb, lsb, inj); end
    endtask

    task automatic test_saturation();
        int k2;
        @(negedge clk);
        cs2 = 1'b1;
        @(negedge clk);
        k2  = cyc;
        cs2 = 1'b0;
        repeat (k2 + SC2 + (1 << WW2) - cyc) @(negedge clk);
        compared++; if (meas2 !== 12'h000 || busy2 !== 1'b1)
            begin failed++; $display("FAIL sat_before: got meas=%h busy=%b want 000 1", meas2, busy2); end
        @(negedge clk);
        compared++; if (meas2 !== 12'hFFF) begin failed++; $display("FAIL sat_meas: got %h want fff", meas2); end
    endtask

    initial begin
        test_reset();
        test_model_lock();
        test_restart_locked();
        test_all_clear();
        test_rst_lsb();
        test_saturation();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
        $finish;
    end

endmodule

// File: doc/osc_lock_ctrl.md
Name: osc_lock_ctrl

Overview:
- Calibration and lock sequencer for the 5-stage ring oscillator core.
- Runs in the ref_clk domain:
  - enables the ring;
  - tunes the varactor-bank codes (delay_con_msb, then delay_con_lsb) by successive approximation, so the oscillator edge count per reference window matches a target;
  - verifies the result and hands over to edge injection by asserting inj_en.
- Sits between the PLL/CDR configuration registers and the oscillator core.

Parameters:
- CNT_W, 12: width of edge counter, target_cnt, tol_cnt and meas_cnt.
- WIN_W, 8: measurement window is 2^WIN_W ref_clk cycles.
- SETTLE_CYC, 16: ref_clk cycles waited after every code change before measuring (must be ≥1).

Ports:
- ref_clk, in, 1: sole clock.
- rst, in, 1: synchronous, active-high reset.
- cal_start, in, 1: level; a 0→1 transition (registered edge detect) starts calibration.
- target_cnt, in, CNT_W: desired osc_div rising edges per window; sampled at start.
- tol_cnt, in, CNT_W: allowed |final count − target|; sampled at start.
- osc_div_sync, in, 1: divided oscillator, already synchronised to ref_clk.
- glob_en, out, 1: ring enable.
- delay_con_msb, out, 8: coarse varactor code.
- delay_con_lsb, out, 5: fine varactor code.
- inj_en, out, 1: edge injector enable.
- cal_busy, out, 1: calibration in progress.
- cal_done, out, 1: lock sequence complete.
- cal_err, out, 1: final check failed.
- meas_cnt, out, CNT_W: last completed window count.

Behaviour:
- Reset values: glob_en=0, delay_con_msb=8'h80, delay_con_lsb=5'h10, inj_en=0, cal_busy=0, cal_done=0, cal_err=0, meas_cnt=0. FSM goes to IDLE.
- A rst assertion mid-operation aborts immediately to the reset values on the next edge.
- States: IDLE, SETTLE, MEASURE, DECIDE, CHECK, LOCKED.
- IDLE:
  - On a cal_start rising edge: latch target_cnt and tol_cnt; glob_en=1, cal_busy=1, cal_done=0, cal_err=0, inj_en=0.
  - Load msb=8'h80, lsb=5'h10; phase=MSB, bit index=7; go to SETTLE.
- SETTLE: count SETTLE_CYC cycles, then go to MEASURE. The edge detector and edge counter are cleared on entry to MEASURE.
- MEASURE:
  - Lasts exactly 2^WIN_W cycles.
  - Counts cycles where osc_div_sync=1 and its previous registered value=0.
  - Counter saturates at all-ones (no wrap).
  - On the last cycle, meas_cnt takes the final count; go to DECIDE (or CHECK if this is the final pass).
- DECIDE (1 cycle), trial bit = current bit of the active code:
  - Keep the bit if meas_cnt > target (too fast, needs more cap); clear it otherwise. Equal clears.
  - If bit index > 0: set the next lower bit to 1 and go to SETTLE.
  - After msb bit 0: phase=LSB, bit index=4; lsb bit4 is already 1 (trial); go to SETTLE.
  - After lsb bit 0: go to SETTLE for the final verification pass.
- CHECK (1 cycle):
  - cal_err = (|meas_cnt − target| > tol), computed at CNT_W+1 bits with no overflow.
  - Then LOCKED.
- LOCKED: cal_busy=0, cal_done=1, inj_en = ~cal_err. Codes and glob_en hold.
- New cal_start rising edge in LOCKED: restarts from IDLE's start actions (inj_en drops the same cycle).
- cal_start edges while busy are ignored.
- Codes change only on DECIDE exit or start; they are stable throughout SETTLE/MEASURE.
- Total latency start→cal_done: 14 × (SETTLE_CYC + 2^WIN_W + 1) + 2 cycles.

Test Plan:
- Reset: hold rst 3 cycles with osc toggling → every output at its reset value; no state change.
- Model N = 512 − msb per window (lsb ignored), target=400, tol=2 → msb=8'h6F, lsb=5'h1F, meas_cnt=401, cal_err=0, inj_en=1, cal_done=1 exactly at the latency formula.
- Model N = 300 constant, target=400, tol=4 → all trial bits cleared: msb=8'h00, lsb=5'h00, cal_err=1, inj_en=0.
- osc_div_sync toggling every cycle with WIN_W=13 (>4095 edges) → meas_cnt saturates at 12'hFFF, no wrap.
- Pulse cal_start again during MEASURE → ignored; pulse it in LOCKED → inj_en=0 next cycle, msb=8'h80, lsb=5'h10, cal_busy=1.
- Assert rst during the LSB phase → reset values next cycle; a subsequent cal_start completes normally.
